// File: rtl/sa_autosa_csb_shadow_regif.sv
// CSB slave front-end for the memory-interface arbiter configuration.
// A one-stage request pipeline decodes CSB accesses into shadow OS-count
// and client-weight registers. A commit FSM copies shadow to active while
// the datapath reports idle, and gives up after COMMIT_TIMEOUT cycles.
module sa_autosa_csb_shadow_regif #(
  parameter int          NUM_RD_CLIENTS = 12,
  parameter int          NUM_WR_CLIENTS = 8,
  parameter logic [11:0] BASE_PAGE      = 12'h000,
  parameter logic [7:0]  RST_WEIGHT     = 8'h01,
  parameter logic [7:0]  RST_OS_CNT     = 8'hFF,
  parameter int          COMMIT_TIMEOUT = 1024
) (
  input  logic                          autosa_core_clk,
  input  logic                          autosa_core_rstn,
  input  logic                          csb2xx_req_pvld,
  output logic                          csb2xx_req_prdy,
  input  logic [62:0]                   csb2xx_req_pd,
  output logic                          xx2csb_resp_valid,
  output logic [33:0]                   xx2csb_resp_pd,
  input  logic                          dp2reg_idle,
  output logic [7:0]                    reg2dp_rd_os_cnt,
  output logic [7:0]                    reg2dp_wr_os_cnt,
  output logic [8*NUM_RD_CLIENTS-1:0]   reg2dp_rd_weight,
  output logic [8*NUM_WR_CLIENTS-1:0]   reg2dp_wr_weight,
  output logic                          reg2dp_cfg_update
);

  localparam int RW      = (NUM_RD_CLIENTS + 3) / 4;
  localparam int WW      = (NUM_WR_CLIENTS + 3) / 4;
  localparam int RD_BASE = 4;
  localparam int WR_BASE = 4 + RW;
  localparam int WR_END  = 4 + RW + WW;
  localparam int TMR_W   = (COMMIT_TIMEOUT > 2) ? $clog2(COMMIT_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(COMMIT_TIMEOUT - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_e;

  // FSM state
  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               commit_s, timeout_s;

  // request stage
  logic               s1_vld_q, s1_vld_d;
  logic [62:0]        s1_pd_q, s1_pd_d;

  // shadow and active registers
  logic [7:0]         sh_rd_os_q, sh_rd_os_d, sh_wr_os_q, sh_wr_os_d;
  logic [7:0]         sh_rd_w_q [NUM_RD_CLIENTS];
  logic [7:0]         sh_rd_w_d [NUM_RD_CLIENTS];
  logic [7:0]         sh_wr_w_q [NUM_WR_CLIENTS];
  logic [7:0]         sh_wr_w_d [NUM_WR_CLIENTS];
  logic [7:0]         act_rd_os_q, act_rd_os_d, act_wr_os_q, act_wr_os_d;
  logic [7:0]         act_rd_w_q [NUM_RD_CLIENTS];
  logic [7:0]         act_rd_w_d [NUM_RD_CLIENTS];
  logic [7:0]         act_wr_w_q [NUM_WR_CLIENTS];
  logic [7:0]         act_wr_w_d [NUM_WR_CLIENTS];
  logic               cfg_update_q, cfg_update_d;

  // status and response
  logic               sticky_q, sticky_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic               resp_valid_q, resp_valid_d;
  logic [33:0]        resp_pd_q, resp_pd_d;

  // decode helpers
  logic               wr_s, np_s, page_hit_s, mapped_s, null_wr_s, err_s, wr_en_s;
  logic               commit_req_s, sticky_clr_s;
  logic [3:0]         be_s;
  logic [31:0]        wdat_s, rdat_s;
  int                 off_i;
  logic               unused_pd_s;

  assign wr_s        = s1_pd_q[54];
  assign np_s        = s1_pd_q[55];
  assign be_s        = s1_pd_q[60:57];
  assign wdat_s      = s1_pd_q[53:22];
  assign unused_pd_s = ^{s1_pd_q[62:61], s1_pd_q[56]};

  // Requests are only accepted while no commit is pending.
  assign csb2xx_req_prdy = (state_q == ST_IDLE);

  // Commit FSM state register
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Commit FSM next state: idle on the terminal cycle still commits
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_IDLE: begin
        if (commit_req_s) begin
          state_d = ST_PEND;
          tmr_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (dp2reg_idle) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == TMR_LAST) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d   = tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Commit FSM outputs: copy strobe and timeout strobe
  always_comb begin
    commit_s  = 1'b0;
    timeout_s = 1'b0;
    case (state_q)
      ST_PEND: begin
        if (dp2reg_idle) begin
          commit_s = 1'b1;
        end else begin
          timeout_s = (tmr_q == TMR_LAST);
        end
      end
      default: begin
        commit_s  = 1'b0;
        timeout_s = 1'b0;
      end
    endcase
  end

  // Address decode, read mux, error classification
  always_comb begin
    off_i      = int'({22'd0, s1_pd_q[9:0]});
    page_hit_s = (s1_pd_q[21:10] == BASE_PAGE);
    mapped_s   = (off_i <= 2) || ((off_i >= RD_BASE) && (off_i < WR_END));
    null_wr_s  = wr_s && (be_s == 4'b0000);
    err_s      = s1_vld_q && !null_wr_s &&
                 (!page_hit_s || !mapped_s || (wr_s && (off_i == 2)));
    wr_en_s    = s1_vld_q && wr_s && !null_wr_s && !err_s;
    rdat_s     = 32'd0;
    if (off_i == 0) begin
      rdat_s = {16'd0, sh_wr_os_q, sh_rd_os_q};
    end else if (off_i == 2) begin
      rdat_s = {8'd0, err_cnt_q, 13'd0, sticky_q, dp2reg_idle, (state_q == ST_PEND)};
    end else begin
      rdat_s = 32'd0;
    end
    for (int i = 0; i < NUM_RD_CLIENTS; i++) begin
      if (off_i == RD_BASE + i / 4) begin
        rdat_s[8*(i%4) +: 8] = sh_rd_w_q[i];
      end else begin
        rdat_s[8*(i%4) +: 8] = rdat_s[8*(i%4) +: 8];
      end
    end
    for (int i = 0; i < NUM_WR_CLIENTS; i++) begin
      if (off_i == WR_BASE + i / 4) begin
        rdat_s[8*(i%4) +: 8] = sh_wr_w_q[i];
      end else begin
        rdat_s[8*(i%4) +: 8] = rdat_s[8*(i%4) +: 8];
      end
    end
    commit_req_s = wr_en_s && (off_i == 1) && be_s[0] && wdat_s[0];
    sticky_clr_s = wr_en_s && (off_i == 1) && be_s[0] && wdat_s[1];
  end

  // Next values for request stage, shadow, active, status and response
  always_comb begin
    s1_vld_d = csb2xx_req_pvld && csb2xx_req_prdy;
    if (s1_vld_d) begin
      s1_pd_d = csb2xx_req_pd;
    end else begin
      s1_pd_d = s1_pd_q;
    end
    sh_rd_os_d = sh_rd_os_q;
    sh_wr_os_d = sh_wr_os_q;
    if (wr_en_s && (off_i == 0)) begin
      if (be_s[0]) sh_rd_os_d = wdat_s[7:0];  else sh_rd_os_d = sh_rd_os_q;
      if (be_s[1]) sh_wr_os_d = wdat_s[15:8]; else sh_wr_os_d = sh_wr_os_q;
    end else begin
      sh_rd_os_d = sh_rd_os_q;
    end
    for (int i = 0; i < NUM_RD_CLIENTS; i++) begin
      if (wr_en_s && (off_i == RD_BASE + i / 4) && be_s[i%4]) begin
        sh_rd_w_d[i] = wdat_s[8*(i%4) +: 8];
      end else begin
        sh_rd_w_d[i] = sh_rd_w_q[i];
      end
      act_rd_w_d[i] = commit_s ? sh_rd_w_q[i] : act_rd_w_q[i];
    end
    for (int i = 0; i < NUM_WR_CLIENTS; i++) begin
      if (wr_en_s && (off_i == WR_BASE + i / 4) && be_s[i%4]) begin
        sh_wr_w_d[i] = wdat_s[8*(i%4) +: 8];
      end else begin
        sh_wr_w_d[i] = sh_wr_w_q[i];
      end
      act_wr_w_d[i] = commit_s ? sh_wr_w_q[i] : act_wr_w_q[i];
    end
    act_rd_os_d  = commit_s ? sh_rd_os_q : act_rd_os_q;
    act_wr_os_d  = commit_s ? sh_wr_os_q : act_wr_os_q;
    cfg_update_d = commit_s;
    // a clear and a timeout in the same cycle leave the sticky set
    sticky_d = sticky_q;
    if (sticky_clr_s) sticky_d = 1'b0; else sticky_d = sticky_q;
    if (timeout_s)    sticky_d = 1'b1; else sticky_d = sticky_d;
    if (err_s && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
    resp_valid_d = s1_vld_q && (!wr_s || np_s);
    if (resp_valid_d) begin
      resp_pd_d = {wr_s, err_s, (wr_s || err_s) ? 32'd0 : rdat_s};
    end else begin
      resp_pd_d = resp_pd_q;
    end
  end

  // Datapath registers
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      s1_vld_q     <= 1'b0;
      s1_pd_q      <= 63'd0;
      sh_rd_os_q   <= RST_OS_CNT;
      sh_wr_os_q   <= RST_OS_CNT;
      act_rd_os_q  <= RST_OS_CNT;
      act_wr_os_q  <= RST_OS_CNT;
      for (int i = 0; i < NUM_RD_CLIENTS; i++) begin
        sh_rd_w_q[i]  <= RST_WEIGHT;
        act_rd_w_q[i] <= RST_WEIGHT;
      end
      for (int i = 0; i < NUM_WR_CLIENTS; i++) begin
        sh_wr_w_q[i]  <= RST_WEIGHT;
        act_wr_w_q[i] <= RST_WEIGHT;
      end
      cfg_update_q <= 1'b0;
      sticky_q     <= 1'b0;
      err_cnt_q    <= 8'd0;
      resp_valid_q <= 1'b0;
      resp_pd_q    <= 34'd0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_pd_q      <= s1_pd_d;
      sh_rd_os_q   <= sh_rd_os_d;
      sh_wr_os_q   <= sh_wr_os_d;
      act_rd_os_q  <= act_rd_os_d;
      act_wr_os_q  <= act_wr_os_d;
      for (int i = 0; i < NUM_RD_CLIENTS; i++) begin
        sh_rd_w_q[i]  <= sh_rd_w_d[i];
        act_rd_w_q[i] <= act_rd_w_d[i];
      end
      for (int i = 0; i < NUM_WR_CLIENTS; i++) begin
        sh_wr_w_q[i]  <= sh_wr_w_d[i];
        act_wr_w_q[i] <= act_wr_w_d[i];
      end
      cfg_update_q <= cfg_update_d;
      sticky_q     <= sticky_d;
      err_cnt_q    <= err_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_pd_q    <= resp_pd_d;
    end
  end

  // Pack active registers onto the datapath outputs
  always_comb begin
    for (int i = 0; i < NUM_RD_CLIENTS; i++) begin
      reg2dp_rd_weight[8*i +: 8] = act_rd_w_q[i];
    end
    for (int i = 0; i < NUM_WR_CLIENTS; i++) begin
      reg2dp_wr_weight[8*i +: 8] = act_wr_w_q[i];
    end
  end

  assign reg2dp_rd_os_cnt  = act_rd_os_q;
  assign reg2dp_wr_os_cnt  = act_wr_os_q;
  assign reg2dp_cfg_update = cfg_update_q;
  assign xx2csb_resp_valid = resp_valid_q;
  assign xx2csb_resp_pd    = resp_pd_q;

endmodule

// File: tb/tb_sa_autosa_csb_shadow_regif.sv
// Directed self-checking bench for sa_autosa_csb_shadow_regif
// (12 read clients, 8 write clients, commit timeout of 8 cycles).
module tb_sa_autosa_csb_shadow_regif;

  logic         clk;
  logic         rstn;
  logic         pvld;
  logic         prdy;
  logic [62:0]  pd;
  logic         resp_valid;
  logic [33:0]  resp_pd;
  logic         idle;
  logic [7:0]   rd_os, wr_os;
  logic [95:0]  rd_w;
  logic [63:0]  wr_w;
  logic         cfg_update;

  int n_checks = 0;
  int n_fail   = 0;

  sa_autosa_csb_shadow_regif #(
    .NUM_RD_CLIENTS (12),
    .NUM_WR_CLIENTS (8),
    .BASE_PAGE      (12'h000),
    .RST_WEIGHT     (8'h01),
    .RST_OS_CNT     (8'hFF),
    .COMMIT_TIMEOUT (8)
  ) dut (
    .autosa_core_clk   (clk),
    .autosa_core_rstn  (rstn),
    .csb2xx_req_pvld   (pvld),
    .csb2xx_req_prdy   (prdy),
    .csb2xx_req_pd     (pd),
    .xx2csb_resp_valid (resp_valid),
    .xx2csb_resp_pd    (resp_pd),
    .dp2reg_idle       (idle),
    .reg2dp_rd_os_cnt  (rd_os),
    .reg2dp_wr_os_cnt  (wr_os),
    .reg2dp_rd_weight  (rd_w),
    .reg2dp_wr_weight  (wr_w),
    .reg2dp_cfg_update (cfg_update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One isolated CSB transaction; returns at the negedge of cycle N+2.
  task automatic do_req(input string tag, input logic wr, input logic np,
                        input logic [3:0] be, input logic [21:0] addr,
                        input logic [31:0] wdat, input logic exp_v,
                        input logic [33:0] exp_pd);
    @(negedge clk);
    chk({tag, "_prdy"}, {127'd0, prdy}, 128'd1);
    pvld = 1'b1;
    pd   = {2'b00, be, 1'b0, np, wr, wdat, addr};
    @(posedge clk);
    @(negedge clk);
    pvld = 1'b0;
    chk({tag, "_lat"}, {127'd0, resp_valid}, 128'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vld"}, {127'd0, resp_valid}, {127'd0, exp_v});
    if (exp_v) chk({tag, "_pd"}, {94'd0, resp_pd}, {94'd0, exp_pd});
  endtask

  // Counts prdy-low cycles and cfg_update pulses over a window.
  task automatic watch(input int cycles, output int low_cnt, output int upd_cnt);
    low_cnt = 0;
    upd_cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      if (!prdy) low_cnt++;
      if (cfg_update) upd_cnt++;
      @(negedge clk);
    end
  endtask

  int lowc, updc;

  initial begin
    rstn = 1'b0;
    pvld = 1'b0;
    pd   = 63'd0;
    idle = 1'b1;
    repeat (3) @(negedge clk);

    // Test 1: reset state and default reads
    chk("rst_prdy",   {127'd0, prdy},       128'd1);
    chk("rst_rvld",   {127'd0, resp_valid}, 128'd0);
    chk("rst_rpd",    {94'd0, resp_pd},     128'd0);
    chk("rst_rdos",   {120'd0, rd_os},      128'h00FF);
    chk("rst_wros",   {120'd0, wr_os},      128'h00FF);
    chk("rst_rdw",    {32'd0, rd_w},        {32'd0, {12{8'h01}}});
    chk("rst_wrw",    {64'd0, wr_w},        {64'd0, {8{8'h01}}});
    chk("rst_upd",    {127'd0, cfg_update}, 128'd0);
    rstn = 1'b1;
    do_req("rd_off0", 1'b0, 1'b0, 4'h0, 22'd0, 32'd0, 1'b1, {2'b00, 32'h0000FFFF});
    do_req("rd_off4", 1'b0, 1'b0, 4'h0, 22'd4, 32'd0, 1'b1, {2'b00, 32'h01010101});
    do_req("rd_off6", 1'b0, 1'b0, 4'h0, 22'd6, 32'd0, 1'b1, {2'b00, 32'h01010101});
    do_req("rd_off8", 1'b0, 1'b0, 4'h0, 22'd8, 32'd0, 1'b1, {2'b00, 32'h01010101});

    // Test 2: posted byte-enabled write updates shadow only
    do_req("wr_off4", 1'b1, 1'b0, 4'b0101, 22'd4, 32'h44332211, 1'b0, 34'd0);
    do_req("rd_off4b", 1'b0, 1'b0, 4'h0, 22'd4, 32'd0, 1'b1, {2'b00, 32'h01330111});
    chk("act_unchg", {96'd0, rd_w[31:0]}, 128'h01010101);
    do_req("wr_cfgos", 1'b1, 1'b1, 4'b0001, 22'd0, 32'h0000AB5A, 1'b1, {2'b10, 32'd0});
    do_req("rd_cfgos", 1'b0, 1'b0, 4'h0, 22'd0, 32'd0, 1'b1, {2'b00, 32'h0000FF5A});

    // Test 3: commit with datapath idle
    do_req("commit1", 1'b1, 1'b0, 4'b0001, 22'd1, 32'h1, 1'b0, 34'd0);
    watch(12, lowc, updc);
    chk("c1_lowcnt", 128'(lowc), 128'd1);
    chk("c1_updcnt", 128'(updc), 128'd1);
    chk("c1_rdw",  {32'd0, rd_w}, {32'd0, 64'h0101010101010101, 32'h01330111});
    chk("c1_rdos", {120'd0, rd_os}, 128'h005A);

    // Test 4: commit timeout while datapath busy
    do_req("wr_off4c", 1'b1, 1'b0, 4'b1111, 22'd4, 32'hAABBCCDD, 1'b0, 34'd0);
    idle = 1'b0;
    do_req("commit2", 1'b1, 1'b0, 4'b0001, 22'd1, 32'h1, 1'b0, 34'd0);
    watch(20, lowc, updc);
    chk("c2_lowcnt", 128'(lowc), 128'd8);
    chk("c2_updcnt", 128'(updc), 128'd0);
    chk("c2_rdw", {96'd0, rd_w[31:0]}, 128'h01330111);
    do_req("st_tmo", 1'b0, 1'b0, 4'h0, 22'd2, 32'd0, 1'b1, {2'b00, 32'h00000004});
    do_req("clr_tmo", 1'b1, 1'b0, 4'b0001, 22'd1, 32'h2, 1'b0, 34'd0);
    do_req("st_clr", 1'b0, 1'b0, 4'h0, 22'd2, 32'd0, 1'b1, {2'b00, 32'h00000000});
    idle = 1'b1;

    // Test 5: error responses and saturating error count
    do_req("wr_stat", 1'b1, 1'b1, 4'b1111, 22'd2, 32'hFFFFFFFF, 1'b1, {2'b11, 32'd0});
    do_req("rd_miss", 1'b0, 1'b0, 4'h0, {12'h001, 10'd4}, 32'd0, 1'b1, {2'b01, 32'd0});
    do_req("rd_off9", 1'b0, 1'b0, 4'h0, 22'd9, 32'd0, 1'b1, {2'b01, 32'd0});
    do_req("wr_nobe", 1'b1, 1'b1, 4'b0000, 22'd2, 32'hFFFFFFFF, 1'b1, {2'b10, 32'd0});
    do_req("rd_ctrl", 1'b0, 1'b0, 4'h0, 22'd1, 32'd0, 1'b1, {2'b00, 32'd0});
    do_req("st_err3", 1'b0, 1'b0, 4'h0, 22'd2, 32'd0, 1'b1, {2'b00, 32'h00030002});
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      pvld = 1'b1;
      pd   = {2'b00, 4'b1111, 1'b0, 1'b0, 1'b1, 32'h12345678, 22'd3};
      @(posedge clk);
      @(negedge clk);
      pvld = 1'b0;
    end
    do_req("st_sat", 1'b0, 1'b0, 4'h0, 22'd2, 32'd0, 1'b1, {2'b00, 32'h00FF0002});

    // Test 6: reset asserted while a commit is pending
    idle = 1'b0;
    do_req("commit3", 1'b1, 1'b0, 4'b0001, 22'd1, 32'h1, 1'b0, 34'd0);
    chk("p3_prdy", {127'd0, prdy}, 128'd0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mr_prdy", {127'd0, prdy},       128'd1);
    chk("mr_rdw",  {32'd0, rd_w},        {32'd0, {12{8'h01}}});
    chk("mr_rdos", {120'd0, rd_os},      128'h00FF);
    chk("mr_rvld", {127'd0, resp_valid}, 128'd0);
    chk("mr_rpd",  {94'd0, resp_pd},     128'd0);
    chk("mr_upd",  {127'd0, cfg_update}, 128'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_prdy", {127'd0, prdy}, 128'd1);
    do_req("rd_off4r", 1'b0, 1'b0, 4'h0, 22'd4, 32'd0, 1'b1, {2'b00, 32'h01010101});
    do_req("st_rst",   1'b0, 1'b0, 4'h0, 22'd2, 32'd0, 1'b1, {2'b00, 32'h00000000});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
